// File: rtl/mux_varredura.sv
// mux_varredura: registered N:1 multiplexer with manual select and an
// automatic round-robin scan over the channels enabled in a mask.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   D        - packed channel data, channel k = D[k*W +: W]
//   S        - channel select (manual mode)
//   modo     - 0 = manual, 1 = scan
//   mascara  - scan-eligible channels, bit k enables channel k
//   Y        - registered data of the selected channel
//   canal    - index of the channel currently on Y
//   valido   - Y holds real channel data
//   troca    - one-cycle pulse when canal changes value
module mux_varredura #(
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  D,
    input  logic [SW-1:0]   S,
    input  logic            modo,
    input  logic [N-1:0]    mascara,
    output logic [W-1:0]    Y,
    output logic [SW-1:0]   canal,
    output logic            valido,
    output logic            troca
);

    // DWELL = 1 still needs a one-bit counter so the register is legal.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {MANUAL, VARRE, PARADO} estado_t;

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   canal_q, canal_d;
    logic [W-1:0]    y_q, y_d;
    logic            valido_q, valido_d;
    logic            troca_q, troca_d;

    // Next enabled channel strictly after c, wrapping N-1 -> 0. The last
    // offset tried is N, i.e. c itself, so a lone enabled channel maps to
    // itself and the scan stays put without a troca pulse.
    function automatic logic [SW-1:0] prox(input logic [SW-1:0] c,
                                           input logic [N-1:0]  m);
        logic [SW-1:0] r;
        logic          achou;
        int            idx;
        r     = c;
        achou = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(c) + off) % N;
            if (!achou && m[idx]) begin
                r     = SW'(idx);
                achou = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        estado_d = estado_q;
        canal_d  = canal_q;
        cnt_d    = '0;
        valido_d = 1'b0;
        y_d      = '0;

        if (!modo) begin
            // Manual: an out-of-range select blanks Y but leaves canal alone.
            estado_d = MANUAL;
            if (int'(S) < N) begin
                canal_d  = S;
                valido_d = 1'b1;
            end
        end else if (mascara == '0) begin
            estado_d = PARADO;
        end else begin
            estado_d = VARRE;
            valido_d = 1'b1;
            if (estado_q == MANUAL && mascara[canal_q]) begin
                // Entering scan on an enabled channel: give it a full dwell.
                canal_d = canal_q;
            end else if (estado_q != VARRE || !mascara[canal_q]) begin
                // Leaving PARADO, or the current channel is not eligible.
                canal_d = prox(canal_q, mascara);
            end else if (cnt_q == CW'(DWELL - 1)) begin
                canal_d = prox(canal_q, mascara);
            end else begin
                canal_d = canal_q;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        // Y is loaded from the same channel index being loaded into canal.
        if (valido_d) begin
            for (int k = 0; k < N; k++) begin
                if (int'(canal_d) == k) y_d = D[k*W +: W];
            end
        end

        troca_d = (canal_d != canal_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= MANUAL;
            cnt_q    <= '0;
            canal_q  <= '0;
            y_q      <= '0;
            valido_q <= 1'b0;
            troca_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            canal_q  <= canal_d;
            y_q      <= y_d;
            valido_q <= valido_d;
            troca_q  <= troca_d;
        end
    end

    assign Y      = y_q;
    assign canal  = canal_q;
    assign valido = valido_q;
    assign troca  = troca_q;

endmodule

// File: tb/tb_mux_varredura.sv
module tb_mux_varredura;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: N=4, W=4, DWELL=3
    logic [15:0] dA;
    logic [1:0]  sA;
    logic        modoA;
    logic [3:0]  mA;
    logic [3:0]  yA;
    logic [1:0]  cA;
    logic        vA, tA;

    // DUT B: N=3, W=8, DWELL=2
    logic [23:0] dB;
    logic [1:0]  sB;
    logic        modoB;
    logic [2:0]  mB;
    logic [7:0]  yB;
    logic [1:0]  cB;
    logic        vB, tB;

    mux_varredura #(.N(4), .W(4), .DWELL(3)) u_a (
        .clk(clk), .rst_n(rst_n), .D(dA), .S(sA), .modo(modoA),
        .mascara(mA), .Y(yA), .canal(cA), .valido(vA), .troca(tA));

    mux_varredura #(.N(3), .W(8), .DWELL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .D(dB), .S(sB), .modo(modoB),
        .mascara(mB), .Y(yB), .canal(cB), .valido(vB), .troca(tB));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chkA(input string tag, input logic [1:0] c, input logic [3:0] y,
                        input logic v, input logic t);
        chk({tag, ".canal"},  32'(cA), 32'(c));
        chk({tag, ".Y"},      32'(yA), 32'(y));
        chk({tag, ".valido"}, 32'(vA), 32'(v));
        chk({tag, ".troca"},  32'(tA), 32'(t));
    endtask

    // Channel data of DUT A is 4'hA + index.
    logic [1:0] seq_scan [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    logic [1:0] seq_1010 [5]  = '{1,1,1,3,3};

    initial begin
        rst_n = 1'b1;
        dA = {4'hD, 4'hC, 4'hB, 4'hA}; sA = 2'd0; modoA = 1'b0; mA = 4'b0000;
        dB = {8'h33, 8'h22, 8'h11};    sB = 2'd0; modoB = 1'b0; mB = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        chkA("rst", 2'd0, 4'h0, 1'b0, 1'b0);
        step;
        chkA("rst_held", 2'd0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual sweep, each select held two cycles
        step; chkA("man0a", 2'd0, 4'hA, 1'b1, 1'b0);
        step; chkA("man0b", 2'd0, 4'hA, 1'b1, 1'b0);
        for (int s = 1; s < 4; s++) begin
            sA = 2'(s);
            step; chkA($sformatf("man%0da", s), 2'(s), 4'(4'hA + s), 1'b1, 1'b1);
            step; chkA($sformatf("man%0db", s), 2'(s), 4'(4'hA + s), 1'b1, 1'b0);
        end

        // Back to channel 0, then full-mask scan
        sA = 2'd0;
        step; chkA("man_back", 2'd0, 4'hA, 1'b1, 1'b1);
        modoA = 1'b1; mA = 4'b1111;
        for (int e = 0; e < 13; e++) begin
            step;
            chkA($sformatf("scan%0d", e), seq_scan[e], 4'(4'hA + seq_scan[e]), 1'b1,
                 (e > 0 && e % 3 == 0));
        end

        // Mask 1010: channel 0 is masked, advance at once to 1
        mA = 4'b1010;
        for (int e = 0; e < 5; e++) begin
            step;
            chk($sformatf("m1010_%0d.canal", e), 32'(cA), 32'(seq_1010[e]));
        end
        // On channel 3 mid-dwell, drop bit 3
        mA = 4'b0010;
        step; chkA("masked3", 2'd1, 4'hB, 1'b1, 1'b1);
        mA = 4'b1010;
        step; chk("cnt_rst1.canal", 32'(cA), 32'd1);
        step; chk("cnt_rst2.canal", 32'(cA), 32'd1);
        step; chkA("cnt_rst3", 2'd3, 4'hD, 1'b1, 1'b1);

        // Empty mask parks the scan
        mA = 4'b0000;
        step; chkA("parado1", 2'd3, 4'h0, 1'b0, 1'b0);
        step; chkA("parado2", 2'd3, 4'h0, 1'b0, 1'b0);
        mA = 4'b0100;
        step; chkA("parado_out", 2'd2, 4'hC, 1'b1, 1'b1);

        // Async reset between edges mid-scan
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkA("async_rst", 2'd0, 4'h0, 1'b0, 1'b0);
        modoA = 1'b0; sA = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        step; chkA("post_rst", 2'd2, 4'hC, 1'b1, 1'b1);

        // DUT B: out-of-range select on N=3, then scan wrapping 2 -> 0
        sB = 2'd3;
        step;
        chk("b_s3.valido", 32'(vB), 32'd0);
        chk("b_s3.Y",      32'(yB), 32'd0);
        chk("b_s3.canal",  32'(cB), 32'd0);
        sB = 2'd2;
        step;
        chk("b_s2.canal", 32'(cB), 32'd2);
        chk("b_s2.Y",     32'(yB), 32'h33);
        modoB = 1'b1; mB = 3'b111;
        step; chk("b_scan0.canal", 32'(cB), 32'd2);
        step; chk("b_scan1.canal", 32'(cB), 32'd2);
        step;
        chk("b_wrap.canal", 32'(cB), 32'd0);
        chk("b_wrap.Y",     32'(yB), 32'h11);
        chk("b_wrap.troca", 32'(tB), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
